// File: rtl/rf_source_tracker_if.sv
// rf_source_tracker_if: rename, commit and checkpoint bus plus the tracked table outputs.
interface rf_source_tracker_if #(
    parameter int AREGS    = 128,
    parameter int RENTRIES = 16,
    parameter int QSLOTS   = 3,
    parameter int CPORTS   = 2,
    parameter int NCHK     = 4
);
    localparam int RW = $clog2(AREGS);
    localparam int RB = $clog2(RENTRIES);
    localparam int CB = NCHK > 1 ? $clog2(NCHK) : 1;
    logic [QSLOTS-1:0]    slot_v;
    logic [QSLOTS-1:0]    slot_enq;
    logic [QSLOTS-1:0]    slot_rfw;
    logic [QSLOTS*RW-1:0] slot_rd;
    logic [QSLOTS*RB-1:0] rob_tails;
    logic [CPORTS-1:0]    cmt_v;
    logic [CPORTS*RW-1:0] cmt_rd;
    logic [CPORTS*RB-1:0] cmt_rid;
    logic                 chk_req;
    logic [CB-1:0]        chk_id;
    logic                 chk_full;
    logic                 chk_free_v;
    logic [CB-1:0]        chk_free_id;
    logic                 branchmiss;
    logic [CB-1:0]        miss_chk;
    logic [NCHK-1:0]      miss_kill;
    logic [AREGS-1:0]     rf_v;
    logic [AREGS*RB-1:0]  rf_source;
    logic                 chk_ovf;
    modport master (
        output slot_v, slot_enq, slot_rfw, slot_rd, rob_tails, cmt_v, cmt_rd, cmt_rid,
               chk_req, chk_free_v, chk_free_id, branchmiss, miss_chk, miss_kill,
        input  chk_id, chk_full, rf_v, rf_source, chk_ovf
    );
    modport slave (
        input  slot_v, slot_enq, slot_rfw, slot_rd, rob_tails, cmt_v, cmt_rd, cmt_rid,
               chk_req, chk_free_v, chk_free_id, branchmiss, miss_chk, miss_kill,
        output chk_id, chk_full, rf_v, rf_source, chk_ovf
    );
endinterface

// File: rtl/rf_source_tracker.sv
// rf_source_tracker: per-register regfile-valid / pending-ROB-id table with multi-slot rename,
// multi-port commit and branch checkpoints restored in a single cycle.
module rf_source_tracker #(
    parameter int AREGS    = 128,
    parameter int RENTRIES = 16,
    parameter int QSLOTS   = 3,
    parameter int CPORTS   = 2,
    parameter int NCHK     = 4,
    parameter int ZREG2    = 64
) (
    input logic clk,
    input logic rst,
    rf_source_tracker_if.slave bus
);
    localparam int RW = $clog2(AREGS);
    localparam int RB = $clog2(RENTRIES);
    localparam int CB = NCHK > 1 ? $clog2(NCHK) : 1;

    logic [AREGS-1:0] v_q, v_d;
    logic [RB-1:0]    src_q [AREGS];
    logic [RB-1:0]    src_d [AREGS];
    logic [AREGS-1:0] cv_q [NCHK];
    logic [AREGS-1:0] cv_d [NCHK];
    logic [RB-1:0]    cs_q [NCHK][AREGS];
    logic [RB-1:0]    cs_d [NCHK][AREGS];
    logic [NCHK-1:0]  alloc_q, alloc_d;
    logic             ovf_q, ovf_d;
    logic [AREGS-1:0] ren;
    logic [RB-1:0]    ren_src [AREGS];
    logic [CB-1:0]    free_id;
    logic             full, take, miss_ok, stop, bv;
    logic [RB-1:0]    bs;
    int               rank;

    function automatic logic cmt_hit(input int r, input logic v, input logic [RB-1:0] s,
                                     input logic [CPORTS-1:0] cv, input logic [CPORTS*RW-1:0] crd,
                                     input logic [CPORTS*RB-1:0] crid);
        cmt_hit = 1'b0;
        for (int j = 0; j < CPORTS; j++)
            cmt_hit |= cv[j] & (crd[j*RW +: RW] == RW'(r)) & ~v & (crid[j*RB +: RB] == s);
    endfunction

    function automatic logic hard(input int r);
        return r == 0 || (ZREG2 != 0 && r == ZREG2);
    endfunction

    // Rank counts enqueued slots below; a valid but stalled slot ends the prefix.
    always_comb begin
        stop = 1'b0;
        rank = 0;
        ren  = '0;
        for (int r = 0; r < AREGS; r++) ren_src[r] = '0;
        for (int i = 0; i < QSLOTS; i++) begin
            stop = stop | (bus.slot_v[i] & ~bus.slot_enq[i]);
            if (bus.slot_v[i] && bus.slot_enq[i] && !stop) begin
                if (bus.slot_rfw[i]) begin
                    ren[bus.slot_rd[i*RW +: RW]]     = 1'b1;
                    ren_src[bus.slot_rd[i*RW +: RW]] = bus.rob_tails[rank*RB +: RB];
                end
                rank = rank + 1;
            end
        end
    end

    always_comb begin
        free_id = '0;
        for (int c = NCHK - 1; c >= 0; c--) if (!alloc_q[c]) free_id = CB'(c);
    end

    assign full = &alloc_q;

    always_comb begin
        miss_ok = bus.branchmiss & alloc_q[bus.miss_chk];
        take    = bus.chk_req & ~full & ~bus.branchmiss;
        bv      = 1'b0;
        bs      = '0;
        for (int r = 0; r < AREGS; r++) begin
            bv       = miss_ok ? cv_q[bus.miss_chk][r] : v_q[r];
            bs       = miss_ok ? cs_q[bus.miss_chk][r] : src_q[r];
            v_d[r]   = hard(r) | ((bus.branchmiss & ~miss_ok) ? v_q[r] :
                       (ren[r] & ~bus.branchmiss) ? 1'b0 :
                       bv | cmt_hit(r, bv, bs, bus.cmt_v, bus.cmt_rd, bus.cmt_rid));
            src_d[r] = hard(r) ? '0 : (ren[r] & ~bus.branchmiss) ? ren_src[r] : bs;
        end
        // Live snapshots absorb commits so a later restore never resurrects a retired id.
        for (int c = 0; c < NCHK; c++) begin
            for (int r = 0; r < AREGS; r++) begin
                cv_d[c][r] = cv_q[c][r] | (alloc_q[c] &
                             cmt_hit(r, cv_q[c][r], cs_q[c][r], bus.cmt_v, bus.cmt_rd, bus.cmt_rid));
                cs_d[c][r] = (take && free_id == CB'(c)) ? src_d[r] : cs_q[c][r];
            end
            if (take && free_id == CB'(c)) cv_d[c] = v_d;
        end
        alloc_d = alloc_q;
        if (bus.chk_free_v) alloc_d[bus.chk_free_id] = 1'b0;
        if (bus.branchmiss) alloc_d = alloc_d & ~bus.miss_kill & ~(NCHK'(1) << bus.miss_chk);
        if (take) alloc_d[free_id] = 1'b1;
        ovf_d = ovf_q | (bus.chk_req & full & ~bus.branchmiss) | (bus.branchmiss & ~miss_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q     <= '1;
            alloc_q <= '0;
            ovf_q   <= 1'b0;
            for (int r = 0; r < AREGS; r++) src_q[r] <= '0;
            for (int c = 0; c < NCHK; c++) begin
                cv_q[c] <= '1;
                for (int r = 0; r < AREGS; r++) cs_q[c][r] <= '0;
            end
        end else begin
            v_q     <= v_d;
            src_q   <= src_d;
            cv_q    <= cv_d;
            cs_q    <= cs_d;
            alloc_q <= alloc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.chk_id   = free_id;
    assign bus.chk_full = full;
    assign bus.chk_ovf  = ovf_q;
    assign bus.rf_v     = v_q;
    for (genvar g = 0; g < AREGS; g++) begin : g_src
        assign bus.rf_source[g*RB +: RB] = src_q[g];
    end
endmodule

// File: tb/tb_rf_source_tracker.sv
// tb_rf_source_tracker: directed vector table for rename/commit plus hand sequences
// for checkpoint allocate/free/restore and overflow.
module tb_rf_source_tracker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run = 0;
    int   n_fail = 0;

    rf_source_tracker_if bus ();
    rf_source_tracker dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  v, e, w;
        logic [20:0] rd;
        logic [11:0] tl;
        logic [1:0]  cv;
        logic [13:0] crd;
        logic [7:0]  crid;
        int p0, p0v, p0s, p1, p1v, p1s, ninv;
    } vec_t;
    vec_t vt [11];

    task automatic chk(input string name, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int gv(input int r);
        return int'(bus.rf_v[r]);
    endfunction

    function automatic int gs(input int r);
        return int'(bus.rf_source[r*4 +: 4]);
    endfunction

    task automatic probe(input string tag, input int r, input int ev, input int es);
        chk($sformatf("%s r%0d valid", tag, r), gv(r), ev);
        if (ev == 0 || r == 0 || r == 64) chk($sformatf("%s r%0d src", tag, r), gs(r), es);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.slot_v = '0; bus.slot_enq = '0; bus.slot_rfw = '0; bus.slot_rd = '0; bus.rob_tails = '0;
        bus.cmt_v = '0; bus.cmt_rd = '0; bus.cmt_rid = '0; bus.chk_req = 1'b0;
        bus.chk_free_v = 1'b0; bus.chk_free_id = '0; bus.branchmiss = 1'b0;
        bus.miss_chk = '0; bus.miss_kill = '0;
    endtask

    task automatic ren0(input int rd, input int tl);
        bus.slot_v = 3'b001; bus.slot_enq = 3'b001; bus.slot_rfw = 3'b001;
        bus.slot_rd = 21'(rd); bus.rob_tails = 12'(tl);
    endtask

    initial begin
        vt[0]  = '{3'b111, 3'b111, 3'b111, {7'd5, 7'd6, 7'd5}, {4'd7, 4'd4, 4'd3}, 2'b00, 14'd0, 8'd0, 5, 0, 7, 6, 0, 4, 2};
        vt[1]  = '{3'b000, 3'b000, 3'b000, 21'd0, 12'd0, 2'b01, {7'd0, 7'd5}, {4'd0, 4'd3}, 5, 0, 7, 6, 0, 4, 2};
        vt[2]  = '{3'b000, 3'b000, 3'b000, 21'd0, 12'd0, 2'b11, {7'd6, 7'd5}, {4'd4, 4'd7}, 5, 1, 0, 6, 1, 0, 0};
        vt[3]  = '{3'b101, 3'b101, 3'b101, {7'd9, 7'd0, 7'd11}, {4'd3, 4'd2, 4'd1}, 2'b00, 14'd0, 8'd0, 11, 0, 1, 9, 0, 2, 2};
        vt[4]  = '{3'b111, 3'b101, 3'b111, {7'd14, 7'd13, 7'd12}, {4'd7, 4'd6, 4'd5}, 2'b00, 14'd0, 8'd0, 12, 0, 5, 14, 1, 0, 3};
        vt[5]  = '{3'b001, 3'b001, 3'b001, {7'd0, 7'd0, 7'd5}, {4'd0, 4'd0, 4'd7}, 2'b00, 14'd0, 8'd0, 5, 0, 7, 12, 0, 5, 4};
        vt[6]  = '{3'b001, 3'b001, 3'b001, {7'd0, 7'd0, 7'd5}, {4'd0, 4'd0, 4'd2}, 2'b01, {7'd0, 7'd5}, {4'd0, 4'd7}, 5, 0, 2, 9, 0, 2, 4};
        vt[7]  = '{3'b011, 3'b011, 3'b011, {7'd0, 7'd64, 7'd0}, {4'd0, 4'd9, 4'd8}, 2'b00, 14'd0, 8'd0, 0, 1, 0, 64, 1, 0, 4};
        vt[8]  = '{3'b000, 3'b000, 3'b000, 21'd0, 12'd0, 2'b11, {7'd11, 7'd11}, {4'd1, 4'd9}, 11, 1, 0, 12, 0, 5, 3};
        vt[9]  = '{3'b000, 3'b000, 3'b000, 21'd0, 12'd0, 2'b11, {7'd5, 7'd9}, {4'd2, 4'd2}, 9, 1, 0, 5, 1, 0, 1};
        vt[10] = '{3'b000, 3'b000, 3'b000, 21'd0, 12'd0, 2'b01, {7'd0, 7'd12}, {4'd0, 4'd5}, 12, 1, 0, 0, 1, 0, 0};

        idle();
        tick();
        tick();
        rst = 1'b0;
        chk("reset invalid count", $countones(~bus.rf_v), 0);
        chk("reset src any", int'(|bus.rf_source), 0);
        chk("reset chk_full", int'(bus.chk_full), 0);
        chk("reset chk_id", int'(bus.chk_id), 0);
        chk("reset chk_ovf", int'(bus.chk_ovf), 0);

        for (int i = 0; i < 11; i++) begin
            bus.slot_v = vt[i].v; bus.slot_enq = vt[i].e; bus.slot_rfw = vt[i].w;
            bus.slot_rd = vt[i].rd; bus.rob_tails = vt[i].tl;
            bus.cmt_v = vt[i].cv; bus.cmt_rd = vt[i].crd; bus.cmt_rid = vt[i].crid;
            tick();
            idle();
            probe($sformatf("vec%0d", i), vt[i].p0, vt[i].p0v, vt[i].p0s);
            probe($sformatf("vec%0d", i), vt[i].p1, vt[i].p1v, vt[i].p1s);
            chk($sformatf("vec%0d invalid count", i), $countones(~bus.rf_v), vt[i].ninv);
        end

        // Snapshot with a pending rename, retire it behind a re-rename, then restore.
        ren0(10, 1);
        bus.chk_req = 1'b1;
        #1;
        chk("snap chk_id", int'(bus.chk_id), 0);
        tick();
        idle();
        probe("snap", 10, 0, 1);
        ren0(10, 2);
        bus.cmt_v = 2'b01; bus.cmt_rd = 14'd10; bus.cmt_rid = 8'd1;
        tick();
        idle();
        probe("rerename", 10, 0, 2);
        ren0(20, 5);
        bus.chk_req = 1'b1;
        bus.branchmiss = 1'b1;
        bus.miss_chk = '0;
        tick();
        idle();
        probe("restore", 10, 1, 0);
        probe("restore", 20, 1, 0);
        chk("restore invalid count", $countones(~bus.rf_v), 0);
        chk("restore chk_id", int'(bus.chk_id), 0);
        chk("restore chk_full", int'(bus.chk_full), 0);
        chk("restore chk_ovf", int'(bus.chk_ovf), 0);

        // Fill all checkpoints, overflow, then free and re-allocate.
        for (int i = 0; i < 4; i++) begin
            bus.chk_req = 1'b1;
            #1;
            chk($sformatf("alloc%0d chk_id", i), int'(bus.chk_id), i);
            tick();
            idle();
        end
        chk("filled chk_full", int'(bus.chk_full), 1);
        bus.chk_req = 1'b1;
        tick();
        idle();
        chk("overflow chk_ovf", int'(bus.chk_ovf), 1);
        chk("overflow chk_full", int'(bus.chk_full), 1);
        bus.chk_req = 1'b1;
        bus.chk_free_v = 1'b1;
        bus.chk_free_id = 2'd2;
        tick();
        idle();
        chk("freed chk_full", int'(bus.chk_full), 0);
        chk("freed chk_id", int'(bus.chk_id), 2);
        bus.chk_req = 1'b1;
        #1;
        chk("realloc chk_id", int'(bus.chk_id), 2);
        tick();
        idle();
        chk("realloc chk_full", int'(bus.chk_full), 1);

        bus.branchmiss = 1'b1;
        bus.miss_chk = 2'd1;
        bus.miss_kill = 4'b1100;
        tick();
        idle();
        chk("kill chk_full", int'(bus.chk_full), 0);
        chk("kill chk_id", int'(bus.chk_id), 1);
        chk("kill invalid count", $countones(~bus.rf_v), 0);
        bus.chk_free_v = 1'b1;
        bus.chk_free_id = 2'd3;
        tick();
        idle();
        chk("double free chk_id", int'(bus.chk_id), 1);
        bus.chk_req = 1'b1;
        bus.chk_free_v = 1'b1;
        bus.chk_free_id = 2'd0;
        tick();
        idle();
        chk("alloc+free chk_id", int'(bus.chk_id), 0);
        chk("alloc+free chk_full", int'(bus.chk_full), 0);

        // Reset wins over a same-cycle rename; then a restore from a free checkpoint.
        rst = 1'b1;
        ren0(40, 6);
        tick();
        rst = 1'b0;
        idle();
        probe("midrst", 40, 1, 0);
        chk("midrst chk_ovf", int'(bus.chk_ovf), 0);
        chk("midrst chk_id", int'(bus.chk_id), 0);
        ren0(30, 4);
        tick();
        idle();
        bus.branchmiss = 1'b1;
        bus.miss_chk = 2'd2;
        tick();
        idle();
        probe("freemiss", 30, 0, 4);
        chk("freemiss chk_ovf", int'(bus.chk_ovf), 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
